// File: rtl/reflet_boot_pkg.sv
// Shared constants for the boot copier: FSM encoding and the ROM header magic "ASRM".
package reflet_boot_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_LATCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } boot_state_e;

    localparam logic [31:0] MAGIC      = 32'h4153524d;
    localparam int unsigned HEADER_LEN = 4;

    // Header byte 0 is the most significant byte of MAGIC.
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [31:0] sh;
        sh = MAGIC >> {~idx, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/boot_magic_check.sv
// Combinational compare of one header byte against its expected magic value.
module boot_magic_check
    import reflet_boot_pkg::*;
(
    input  logic [1:0] i_idx,
    input  logic [7:0] i_byte,
    output logic       o_match
);

    assign o_match = (i_byte == magic_byte(i_idx));

endmodule

// File: rtl/rom_boot_loader.sv
// Boot copier: streams every ROM byte into RAM through a valid/ready port,
// validating the 4-byte header, then releases the CPU from reset.
module rom_boot_loader
    import reflet_boot_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int ROM_DEPTH      = 256,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_BASE       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [ADDR_WIDTH-1:0]     rom_addr,
    output logic                      rom_enable_out,
    input  logic [7:0]                rom_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]                ram_data,
    output logic                      ram_write_en,
    input  logic                      ram_ready,
    output logic                      cpu_reset,
    output logic                      boot_done,
    output logic                      boot_error
);

    localparam logic [RAM_ADDR_WIDTH-1:0] W_BASE = RAM_ADDR_WIDTH'(RAM_BASE);

    boot_state_e           r_state;
    boot_state_e           w_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [7:0]            r_data;
    logic                  w_match;
    logic                  w_hdr;
    logic                  w_last;

    boot_magic_check u_magic (
        .i_idx   (r_ptr[1:0]),
        .i_byte  (rom_data),
        .o_match (w_match)
    );

    assign w_hdr  = ({1'b0, r_ptr} < (ADDR_WIDTH+1)'(HEADER_LEN));
    assign w_last = (r_ptr == ADDR_WIDTH'(ROM_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_ptr   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_LATCH)
                r_data <= rom_data;
            if (r_state == ST_WRITE && ram_ready && !w_last)
                r_ptr <= r_ptr + 1'b1;
        end
    end

    always_comb begin
        w_next         = r_state;
        rom_addr       = r_ptr;
        rom_enable_out = 1'b0;
        ram_addr       = W_BASE + RAM_ADDR_WIDTH'(r_ptr);
        ram_data       = r_data;
        ram_write_en   = 1'b0;
        cpu_reset      = 1'b1;
        boot_done      = 1'b0;
        boot_error     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                rom_enable_out = 1'b1;
                w_next         = ST_LATCH;
            end
            ST_LATCH: begin
                rom_enable_out = 1'b1;
                w_next         = (w_hdr && !w_match) ? ST_ERROR : ST_WRITE;
            end
            ST_WRITE: begin
                ram_write_en = 1'b1;
                if (ram_ready)
                    w_next = w_last ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                rom_addr  = '0;
                ram_data  = '0;
                cpu_reset = 1'b0;
                boot_done = 1'b1;
            end
            ST_ERROR: begin
                rom_addr   = '0;
                ram_data   = '0;
                boot_error = 1'b1;
            end
            default: w_next = ST_FETCH;
        endcase
        // Reset overrides immediately so a pending write is withdrawn, not accepted.
        if (reset) begin
            rom_addr       = '0;
            rom_enable_out = 1'b0;
            ram_addr       = W_BASE;
            ram_data       = '0;
            ram_write_en   = 1'b0;
            cpu_reset      = 1'b1;
            boot_done      = 1'b0;
            boot_error     = 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Scoreboard bench: stimulus pushes expected RAM writes, a monitor pops and compares them.
module tb_rom_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset  = 1'b1;
    logic reset1 = 1'b1;
    logic ram_ready = 1'b1;

    logic [7:0] rom0 [256];
    logic [7:0] rom1 [256];
    logic [7:0] ram0 [256];
    logic [7:0] ram1 [256];

    // default instance
    logic [7:0] rom_addr0, rom_q0, ram_addr0, ram_data0;
    logic       rom_en0, we0, cpu_rst0, done0, err0;
    // RAM_BASE=0xF0, ROM_DEPTH=32 instance
    logic [7:0] rom_addr1, rom_q1, ram_addr1, ram_data1;
    logic       rom_en1, we1, cpu_rst1, done1, err1;

    rom_boot_loader dut0 (
        .clk(clk), .reset(reset), .rom_addr(rom_addr0), .rom_enable_out(rom_en0),
        .rom_data(rom_q0), .ram_addr(ram_addr0), .ram_data(ram_data0),
        .ram_write_en(we0), .ram_ready(ram_ready), .cpu_reset(cpu_rst0),
        .boot_done(done0), .boot_error(err0)
    );

    rom_boot_loader #(.ADDR_WIDTH(8), .ROM_DEPTH(32), .RAM_ADDR_WIDTH(8), .RAM_BASE(8'hF0)) dut1 (
        .clk(clk), .reset(reset1), .rom_addr(rom_addr1), .rom_enable_out(rom_en1),
        .rom_data(rom_q1), .ram_addr(ram_addr1), .ram_data(ram_data1),
        .ram_write_en(we1), .ram_ready(ram_ready), .cpu_reset(cpu_rst1),
        .boot_done(done1), .boot_error(err1)
    );

    // Registered, enable-gated ROMs
    always_ff @(posedge clk) begin
        rom_q0 <= rom_en0 ? rom0[rom_addr0] : 8'h00;
        rom_q1 <= rom_en1 ? rom1[rom_addr1] : 8'h00;
    end

    int errors = 0;
    int checks = 0;
    int wr0 = 0;
    int wr1 = 0;
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitors: a write is accepted at the edge following a cycle with valid && ready.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (we0 && ram_ready && !reset) begin
                if (q0.size() == 0) chk("wr0_unexpected", {ram_addr0, ram_data0}, 64'hDEAD);
                else begin
                    e = q0.pop_front();
                    chk("wr0_addr", ram_addr0, e[15:8]);
                    chk("wr0_data", ram_data0, e[7:0]);
                end
                ram0[ram_addr0] = ram_data0;
                wr0++;
            end
            if (we1 && ram_ready && !reset1) begin
                if (q1.size() == 0) chk("wr1_unexpected", {ram_addr1, ram_data1}, 64'hDEAD);
                else begin
                    e = q1.pop_front();
                    chk("wr1_addr", ram_addr1, e[15:8]);
                    chk("wr1_data", ram_data1, e[7:0]);
                end
                ram1[ram_addr1] = ram_data1;
                wr1++;
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1; reset1 = 1'b1; ram_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state0", {rom_addr0, rom_en0, ram_addr0, ram_data0, we0, cpu_rst0, done0, err0},
            {8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        chk("reset_ram_base1", ram_addr1, 8'hF0);
    endtask

    // Cycle n=1 is the first cycle after the last edge that samples reset high.
    task automatic run(input bit use1, input int stall_at, input int rst_at,
                       output int done_n, output int done1_n);
        int n;
        bit bad;
        n = 0; done_n = -1; done1_n = -1; bad = 0;
        @(posedge clk); #1;
        for (int k = 1; k <= 3000; k++) begin
            n++;
            if (k == rst_at + 1) n = 1;
            reset = (k == rst_at);
            reset1 = use1 ? reset : 1'b1;
            ram_ready = !(stall_at > 0 && n >= stall_at && n < stall_at + 5);
            @(negedge clk);
            if (use1 && k == 1) chk("first_fetch_en", rom_en0, 1'b1);
            if (rst_at > 0 && k == rst_at + 1) chk("we_after_reset", we0, 1'b0);
            if (stall_at > 0 && n >= stall_at && n < stall_at + 5)
                if (!(we0 && ram_addr0 == 8'd7 && ram_data0 == rom0[7])) bad = 1;
            if (use1 && done1_n < 0 && done1) done1_n = n;
            if (!cpu_rst0) begin
                done_n = n;
                break;
            end
            @(posedge clk); #1;
        end
        if (stall_at > 0) chk("stall_hold", bad, 1'b0);
    endtask

    initial begin
        int d0, d1, e_n, bad, w;
        for (int i = 0; i < 256; i++) rom0[i] = 8'(i * 37 + 5);
        rom0[0] = 8'h41; rom0[1] = 8'h53; rom0[2] = 8'h52; rom0[3] = 8'h4d; rom0[4] = 8'h14;
        for (int i = 0; i < 256; i++) rom1[i] = rom0[i];

        // Valid image on both instances, ready tied high
        apply_reset();
        for (int i = 0; i < 256; i++) q0.push_back({8'(i), rom0[i]});
        for (int i = 0; i < 32; i++) q1.push_back({8'(8'hF0 + i), rom1[i]});
        run(1'b1, 0, 0, d0, d1);
        chk("done_cycle0", d0, 769);
        chk("boot_done0", done0, 1'b1);
        chk("done_cycle1", d1, 97);
        chk("cpu_reset1", cpu_rst1, 1'b0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("ram0_byte4", ram0[4], 8'h14);
        chk("ram1_wrap_lo", ram1[8'h0F], rom0[31]);
        chk("ram1_wrap_hi", ram1[8'hF0], rom0[0]);

        // ram_ready low for 5 cycles on byte 7
        apply_reset();
        for (int i = 0; i < 256; i++) q0.push_back({8'(i), rom0[i]});
        run(1'b0, 24, 0, d0, d1);
        chk("stall_done_cycle", d0, 774);
        chk("stall_q_drained", q0.size(), 0);

        // Reset pulse while byte 100 is in WRITE (cycle 303)
        apply_reset();
        for (int i = 0; i < 100; i++) q0.push_back({8'(i), rom0[i]});
        for (int i = 0; i < 256; i++) q0.push_back({8'(i), rom0[i]});
        run(1'b0, 0, 303, d0, d1);
        chk("rst_done_cycle", d0, 769);
        chk("rst_boot_done", done0, 1'b1);
        chk("rst_q_drained", q0.size(), 0);

        // Bad header 41 53 00 4d
        rom0[2] = 8'h00;
        apply_reset();
        q0.push_back({8'h00, 8'h41});
        q0.push_back({8'h01, 8'h53});
        w = wr0;
        e_n = -1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (err0) begin
                e_n = n;
                break;
            end
            @(posedge clk); #1;
        end
        chk("error_cycle", e_n, 9);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!cpu_rst0 || we0 || !err0 || done0) bad++;
        end
        chk("error_hold", bad, 0);
        chk("error_writes", wr0 - w, 2);
        chk("error_q_drained", q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
